mem_read_arbiter: RTL and testbench

- Shares the single memory read channel (rx_* AXI-lite style read port) between two requesters: instruction fetch (ifu_*) and load unit (lsu_*).
- Sits between the IF stage / LSU and the memory-side read slave.
- Allows one outstanding transaction: the grant is locked from arbitration until the data beat handshake completes.
- Fixed priority LSU > IFU, with an anti-starvation counter that forces an IFU grant.

---
 rtl/mem_read_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_read_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// Two-master read arbiter: IFU and LSU share one read channel.
// One transaction in flight; LSU has priority, with IFU anti-starvation.
module mem_read_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_r_valid_i,
  output logic              ifu_r_ready_o,
  input  logic [ADDR_W-1:0] ifu_r_addr_i,
  input  logic [7:0]        ifu_r_size_i,
  output logic [DATA_W-1:0] ifu_data_read_o,
  output logic              ifu_data_valid,
  input  logic              ifu_data_ready,
  input  logic              lsu_r_valid_i,
  output logic              lsu_r_ready_o,
  input  logic [ADDR_W-1:0] lsu_r_addr_i,
  input  logic [7:0]        lsu_r_size_i,
  output logic [DATA_W-1:0] lsu_data_read_o,
  output logic              lsu_data_valid,
  input  logic              lsu_data_ready,
  output logic              rx_r_valid_i,
  input  logic              rx_r_ready_o,
  output logic [ADDR_W-1:0] rx_r_addr_i,
  output logic [7:0]        rx_r_size_i,
  input  logic [DATA_W-1:0] rx_data_read_o,
  input  logic              rx_data_valid,
  output logic              rx_data_ready,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic starved;
  logic sel_valid;
  logic sel_dready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign starved    = (cnt_q == CNT_MAX);
  assign sel_valid  = (grant_q[1] & lsu_r_valid_i)
                    | (grant_q[0] & ifu_r_valid_i);
  assign sel_dready = (grant_q[1] & lsu_data_ready)
                    | (grant_q[0] & ifu_data_ready);

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    ifu_r_ready_o   = 1'b0;
    lsu_r_ready_o   = 1'b0;
    ifu_data_read_o = '0;
    lsu_data_read_o = '0;
    ifu_data_valid  = 1'b0;
    lsu_data_valid  = 1'b0;
    rx_r_valid_i    = 1'b0;
    rx_r_addr_i     = '0;
    rx_r_size_i     = '0;
    rx_data_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Starved IFU overrides LSU priority only when both request
        if (lsu_r_valid_i && !(ifu_r_valid_i && starved)) begin
          grant_d = 2'b10;
          state_d = ADDR;
          if (!ifu_r_valid_i)
            cnt_d = '0;
          else if (!starved)
            cnt_d = cnt_q + CNT_W'(1);
        end else if (ifu_r_valid_i) begin
          grant_d = 2'b01;
          state_d = ADDR;
          cnt_d   = '0;
        end
      end

      ADDR: begin
        rx_r_valid_i  = sel_valid;
        ifu_r_ready_o = grant_q[0] & rx_r_ready_o;
        lsu_r_ready_o = grant_q[1] & rx_r_ready_o;
        unique case (1'b1)
          grant_q[1]: begin
            rx_r_addr_i = lsu_r_addr_i;
            rx_r_size_i = lsu_r_size_i;
          end
          grant_q[0]: begin
            rx_r_addr_i = ifu_r_addr_i;
            rx_r_size_i = ifu_r_size_i;
          end
          default: ;
        endcase
        if (!sel_valid) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (rx_r_ready_o) begin
          state_d = DATA;
        end
      end

      DATA: begin
        ifu_data_read_o = rx_data_read_o;
        lsu_data_read_o = rx_data_read_o;
        ifu_data_valid  = grant_q[0] & rx_data_valid;
        lsu_data_valid  = grant_q[1] & rx_data_valid;
        rx_data_ready   = sel_dready;
        if (rx_data_valid && sel_dready) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter.
// Inputs change 2ns after each rising edge; outputs are sampled 1ns later.
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_r_valid_i;
  logic        ifu_r_ready_o;
  logic [63:0] ifu_r_addr_i;
  logic [7:0]  ifu_r_size_i;
  logic [63:0] ifu_data_read_o;
  logic        ifu_data_valid;
  logic        ifu_data_ready;
  logic        lsu_r_valid_i;
  logic        lsu_r_ready_o;
  logic [63:0] lsu_r_addr_i;
  logic [7:0]  lsu_r_size_i;
  logic [63:0] lsu_data_read_o;
  logic        lsu_data_valid;
  logic        lsu_data_ready;
  logic        rx_r_valid_i;
  logic        rx_r_ready_o;
  logic [63:0] rx_r_addr_i;
  logic [7:0]  rx_r_size_i;
  logic [63:0] rx_data_read_o;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [1:0]  grant_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  int hs_base;

  mem_read_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_ready_o(ifu_r_ready_o),
    .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_size_i(ifu_r_size_i),
    .ifu_data_read_o(ifu_data_read_o),
    .ifu_data_valid(ifu_data_valid), .ifu_data_ready(ifu_data_ready),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_ready_o(lsu_r_ready_o),
    .lsu_r_addr_i(lsu_r_addr_i), .lsu_r_size_i(lsu_r_size_i),
    .lsu_data_read_o(lsu_data_read_o),
    .lsu_data_valid(lsu_data_valid), .lsu_data_ready(lsu_data_ready),
    .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o),
    .rx_r_addr_i(rx_r_addr_i), .rx_r_size_i(rx_r_size_i),
    .rx_data_read_o(rx_data_read_o),
    .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rx_data_valid && rx_data_ready) hs_cnt <= hs_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction with both masters holding valid
  task automatic serve(input logic [1:0] exp, input int idx);
    tick();
    #1;
    chk($sformatf("starve_grant_%0d", idx), {62'd0, grant_o},
        {62'd0, exp});
    chk($sformatf("starve_addr_%0d", idx), rx_r_addr_i,
        exp[1] ? 64'h8000_1000 : 64'h8000_0004);
    rx_r_ready_o = 1'b1;
    tick();
    rx_r_ready_o   = 1'b0;
    rx_data_valid  = 1'b1;
    ifu_data_ready = 1'b1;
    lsu_data_ready = 1'b1;
    tick();
    rx_data_valid  = 1'b0;
    ifu_data_ready = 1'b0;
    lsu_data_ready = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    ifu_r_valid_i  = 1'b0;
    ifu_r_addr_i   = '0;
    ifu_r_size_i   = '0;
    ifu_data_ready = 1'b0;
    lsu_r_valid_i  = 1'b0;
    lsu_r_addr_i   = '0;
    lsu_r_size_i   = '0;
    lsu_data_ready = 1'b0;
    rx_r_ready_o   = 1'b0;
    rx_data_read_o = '0;
    rx_data_valid  = 1'b0;
    #3;
    chk("rst_grant", {62'd0, grant_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_rx_valid", {63'd0, rx_r_valid_i}, 64'd0);
    tick();
    rst_n = 1'b1;

    // 1: IFU alone
    ifu_r_valid_i = 1'b1;
    ifu_r_addr_i  = 64'h8000_0000;
    ifu_r_size_i  = 8'h0F;
    #1;
    chk("t1_idle_ready", {63'd0, ifu_r_ready_o}, 64'd0);
    chk("t1_idle_rxv", {63'd0, rx_r_valid_i}, 64'd0);
    tick();
    #1;
    chk("t1_grant", {62'd0, grant_o}, 64'd1);
    chk("t1_rxv", {63'd0, rx_r_valid_i}, 64'd1);
    chk("t1_addr", rx_r_addr_i, 64'h8000_0000);
    chk("t1_size", {56'd0, rx_r_size_i}, 64'h0F);
    chk("t1_ready_wait", {63'd0, ifu_r_ready_o}, 64'd0);
    tick();
    rx_r_ready_o = 1'b1;
    #1;
    chk("t1_ifu_ready", {63'd0, ifu_r_ready_o}, 64'd1);
    chk("t1_lsu_ready", {63'd0, lsu_r_ready_o}, 64'd0);
    tick();
    ifu_r_valid_i = 1'b0;
    rx_r_ready_o  = 1'b0;
    #1;
    chk("t1_data_rxv", {63'd0, rx_r_valid_i}, 64'd0);
    chk("t1_data_busy", {63'd0, busy_o}, 64'd1);
    chk("t1_dv_early", {63'd0, ifu_data_valid}, 64'd0);
    tick();
    rx_data_valid  = 1'b1;
    rx_data_read_o = 64'h0000_0013_0010_0093;
    ifu_data_ready = 1'b1;
    #1;
    chk("t1_dv", {63'd0, ifu_data_valid}, 64'd1);
    chk("t1_data", ifu_data_read_o, 64'h0000_0013_0010_0093);
    chk("t1_lsu_dv", {63'd0, lsu_data_valid}, 64'd0);
    chk("t1_rx_dready", {63'd0, rx_data_ready}, 64'd1);
    tick();
    rx_data_valid  = 1'b0;
    ifu_data_ready = 1'b0;
    #1;
    chk("t1_end_busy", {63'd0, busy_o}, 64'd0);
    chk("t1_end_grant", {62'd0, grant_o}, 64'd0);

    // 2: simultaneous request
    ifu_r_valid_i = 1'b1;
    ifu_r_addr_i  = 64'h8000_0004;
    lsu_r_valid_i = 1'b1;
    lsu_r_addr_i  = 64'h8000_1000;
    lsu_r_size_i  = 8'hFF;
    tick();
    #1;
    chk("t2_grant_lsu", {62'd0, grant_o}, 64'd2);
    chk("t2_addr_lsu", rx_r_addr_i, 64'h8000_1000);
    chk("t2_size_lsu", {56'd0, rx_r_size_i}, 64'hFF);
    rx_r_ready_o = 1'b1;
    #1;
    chk("t2_lsu_ready", {63'd0, lsu_r_ready_o}, 64'd1);
    chk("t2_ifu_blocked", {63'd0, ifu_r_ready_o}, 64'd0);
    tick();
    lsu_r_valid_i  = 1'b0;
    rx_r_ready_o   = 1'b0;
    rx_data_valid  = 1'b1;
    rx_data_read_o = 64'hDEAD_BEEF_0BAD_F00D;
    lsu_data_ready = 1'b1;
    #1;
    chk("t2_lsu_dv", {63'd0, lsu_data_valid}, 64'd1);
    chk("t2_ifu_dv", {63'd0, ifu_data_valid}, 64'd0);
    chk("t2_bcast", ifu_data_read_o, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    rx_data_valid  = 1'b0;
    lsu_data_ready = 1'b0;
    #1;
    chk("t2_gap_busy", {63'd0, busy_o}, 64'd0);
    tick();
    #1;
    chk("t2_grant_ifu", {62'd0, grant_o}, 64'd1);
    chk("t2_addr_ifu", rx_r_addr_i, 64'h8000_0004);
    rx_r_ready_o = 1'b1;
    tick();
    rx_r_ready_o   = 1'b0;
    ifu_r_valid_i  = 1'b0;
    rx_data_valid  = 1'b1;
    ifu_data_ready = 1'b1;
    tick();
    rx_data_valid  = 1'b0;
    ifu_data_ready = 1'b0;

    // 3: starvation, counter is zero after the IFU grant above
    ifu_r_valid_i = 1'b1;
    lsu_r_valid_i = 1'b1;
    for (int i = 0; i < 10; i++)
      serve((i == 4 || i == 9) ? 2'b01 : 2'b10, i);
    ifu_r_valid_i = 1'b0;
    lsu_r_valid_i = 1'b0;
    #1;
    chk("t3_end_busy", {63'd0, busy_o}, 64'd0);

    // 4: abort while slave stalls
    tick();
    lsu_r_valid_i = 1'b1;
    tick();
    #1;
    chk("t4_grant", {62'd0, grant_o}, 64'd2);
    lsu_r_valid_i = 1'b0;
    #1;
    chk("t4_rxv_drop", {63'd0, rx_r_valid_i}, 64'd0);
    tick();
    rx_data_valid  = 1'b1;
    lsu_data_ready = 1'b1;
    #1;
    chk("t4_grant_clr", {62'd0, grant_o}, 64'd0);
    chk("t4_busy", {63'd0, busy_o}, 64'd0);
    chk("t4_no_dready", {63'd0, rx_data_ready}, 64'd0);
    chk("t4_no_dv", {63'd0, lsu_data_valid}, 64'd0);
    tick();
    rx_data_valid  = 1'b0;
    lsu_data_ready = 1'b0;

    // 5: slow data consumer
    ifu_r_valid_i = 1'b1;
    tick();
    rx_r_ready_o = 1'b1;
    tick();
    hs_base        = hs_cnt;
    ifu_r_valid_i  = 1'b0;
    rx_r_ready_o   = 1'b0;
    rx_data_valid  = 1'b1;
    rx_data_read_o = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t5_hold_dready_%0d", i),
          {63'd0, rx_data_ready}, 64'd0);
      chk($sformatf("t5_hold_busy_%0d", i), {63'd0, busy_o}, 64'd1);
      tick();
    end
    ifu_data_ready = 1'b1;
    #1;
    chk("t5_dready", {63'd0, rx_data_ready}, 64'd1);
    chk("t5_dv", {63'd0, ifu_data_valid}, 64'd1);
    tick();
    rx_data_valid  = 1'b0;
    ifu_data_ready = 1'b0;
    #1;
    chk("t5_done", {63'd0, busy_o}, 64'd0);
    chk("t5_one_hs", 64'(hs_cnt - hs_base), 64'd1);

    // 6: asynchronous reset while in DATA
    lsu_r_valid_i = 1'b1;
    tick();
    rx_r_ready_o = 1'b1;
    tick();
    lsu_r_valid_i  = 1'b0;
    rx_r_ready_o   = 1'b0;
    rx_data_valid  = 1'b1;
    #1;
    chk("t6_pre_busy", {63'd0, busy_o}, 64'd1);
    chk("t6_pre_dv", {63'd0, lsu_data_valid}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {63'd0, busy_o}, 64'd0);
    chk("t6_grant", {62'd0, grant_o}, 64'd0);
    chk("t6_dv", {63'd0, lsu_data_valid}, 64'd0);
    chk("t6_data", lsu_data_read_o, 64'd0);
    tick();
    rx_data_valid = 1'b0;
    rst_n         = 1'b1;
    ifu_r_valid_i = 1'b1;
    ifu_r_addr_i  = 64'h8000_0100;
    tick();
    #1;
    chk("t6_post_grant", {62'd0, grant_o}, 64'd1);
    chk("t6_post_addr", rx_r_addr_i, 64'h8000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
